// File: rtl/dpram_rd_stream.sv
// Streams a block of consecutive RAM port-B words out as valid/ready; optional m_last via DPRAM_RD_LAST_EN.
// Latency: start edge 0 -> first ram_rden the next cycle -> m_valid after edge PIPELINE+2; 1 word/cycle sustained.
// Backpressure: read issue stalls once in-flight reads plus FIFO words reach 4; m_valid/m_data hold until accepted.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld_i,
    input  logic [W-1:0]               wr_dat_i,
    input  logic                       rd_i,
    output logic [W-1:0]               rd_dat_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_vld_i) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(wr_vld_i) - CW'(rd_i);
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
endmodule

module dpram_rd_stream #(
    parameter int DW       = 32,
    parameter int AW       = 8,
    parameter int PIPELINE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
`ifdef DPRAM_RD_LAST_EN
    output logic          m_last,
`endif
    input  logic          m_ready
);
    if (!(PIPELINE == 1 || PIPELINE == 2)) begin : g_bad_pipeline
        $error("dpram_rd_stream: PIPELINE must be 1 or 2");
    end

`ifdef DPRAM_RD_LAST_EN
    localparam int FW = DW + 1;
`else
    localparam int FW = DW;
`endif
    localparam logic [AW:0] LEFT_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ram_addr_q, ram_addr_d;
    logic [AW:0]         rd_left_q, rd_left_d;
    logic [AW:0]         out_left_q, out_left_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PIPELINE-1:0] vld_sr_q, vld_sr_d;
    logic                cap_vld_q;
    logic [FW-1:0]       cap_dat_q, ret_dat;
    logic [FW-1:0]       head_dat;
    logic                fifo_empty, pop, credit_ok;
    logic [2:0]          fifo_cnt, inflight;
    logic [3:0]          occ;

`ifdef DPRAM_RD_LAST_EN
    logic [PIPELINE-1:0] last_sr_q, last_sr_d;
    assign ret_dat = {last_sr_q[PIPELINE-1], ram_q};
`else
    assign ret_dat = ram_q;
`endif

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // Credit covers reads in the RAM pipe, the capture stage and the FIFO; a pop this cycle frees its slot.
    always_comb begin
        inflight = {2'b00, cap_vld_q};
        for (int i = 0; i < PIPELINE; i++) inflight = inflight + {2'b00, vld_sr_q[i]};
        occ       = {1'b0, inflight} + {1'b0, fifo_cnt};
        credit_ok = occ < (4'd4 + {3'b000, pop});
    end

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ram_rden   = 1'b0;
        if (pop) out_left_d = out_left_q - LEFT_ONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d    = READ;
                        ram_addr_d = base_addr;
                        rd_left_d  = len;
                        out_left_d = len;
                        busy_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                ram_rden = (rd_left_q != '0) && credit_ok;
                if (ram_rden) begin
                    ram_addr_d = ram_addr_q + 1'b1;
                    rd_left_d  = rd_left_q - LEFT_ONE;
                    if (rd_left_q == LEFT_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_left_q == LEFT_ONE) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The tail of the valid shift register marks the one cycle ram_q carries issued data.
    always_comb begin
        vld_sr_d    = vld_sr_q << 1;
        vld_sr_d[0] = ram_rden;
`ifdef DPRAM_RD_LAST_EN
        last_sr_d    = last_sr_q << 1;
        last_sr_d[0] = ram_rden && (rd_left_q == LEFT_ONE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ram_addr_q <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_sr_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_dat_q  <= '0;
`ifdef DPRAM_RD_LAST_EN
            last_sr_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_sr_q   <= vld_sr_d;
            cap_vld_q  <= vld_sr_q[PIPELINE-1];
            if (vld_sr_q[PIPELINE-1]) cap_dat_q <= ret_dat;
`ifdef DPRAM_RD_LAST_EN
            last_sr_q  <= last_sr_d;
`endif
        end
    end

    sync_fifo #(.W(FW), .DEPTH(4)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld_i (cap_vld_q),
        .wr_dat_i (cap_dat_q),
        .rd_i     (pop),
        .rd_dat_o (head_dat),
        .empty_o  (fifo_empty),
        .count_o  (fifo_cnt)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_addr = ram_addr_q;
    assign m_data   = head_dat[DW-1:0];
`ifdef DPRAM_RD_LAST_EN
    assign m_last   = m_valid && head_dat[DW];
`endif
endmodule

// File: tb/tb_dpram_rd_stream.sv
// Directed bench: lane 0 runs PIPELINE=1, lane 1 runs PIPELINE=2, each against a RAM holding mem[k] = k*3.
module tb_dpram_rd_stream;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       start_v, busy_v, done_v, rden_v, valid_v, rdy_v;
    logic [1:0][7:0]  base_v, addr_v;
    logic [1:0][8:0]  len_v;
    logic [1:0][31:0] q_v, data_v;
`ifdef DPRAM_RD_LAST_EN
    logic [1:0]       last_v;
`endif
    logic [31:0]      mem [256];
    int               rd_cnt [2];
    int               vectors = 0;
    int               miscompares = 0;
    int               c0;
    int               n;
    int               guard;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) if (rden_v[i]) rd_cnt[i]++;
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [31:0] q1_q, q2_q;
        always @(posedge clk) begin
            if (rden_v[g]) q1_q <= mem[addr_v[g]];
            q2_q <= q1_q;
        end
        assign q_v[g] = (g == 0) ? q1_q : q2_q;

        dpram_rd_stream #(.DW(32), .AW(8), .PIPELINE(g + 1)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .base_addr (base_v[g]),
            .len       (len_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .ram_addr  (addr_v[g]),
            .ram_rden  (rden_v[g]),
            .ram_q     (q_v[g]),
            .m_data    (data_v[g]),
            .m_valid   (valid_v[g]),
`ifdef DPRAM_RD_LAST_EN
            .m_last    (last_v[g]),
`endif
            .m_ready   (rdy_v[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int i, input logic [7:0] b, input logic [8:0] l, output int cnt0);
        cnt0       = rd_cnt[i];
        start_v[i] = 1'b1;
        base_v[i]  = b;
        len_v[i]   = l;
        tick();
        start_v[i] = 1'b0;
    endtask

    // Entered at the negedge after the start edge (edge 0); e counts edges since then.
    task automatic collect(input int i, input logic [7:0] b, input int l, input int cnt0,
                           input int first_exp, input bit contig, input bit chk_addr);
        int         k = 0;
        int         e = 0;
        int         first = -1;
        logic [7:0] a = b;
        logic [7:0] wa;
        while (k < l && e < 400) begin
            if (valid_v[i] && first < 0) first = e;
            if (contig && first >= 0) chk("stream_gap", 32'(valid_v[i]), 32'd1);
            if (chk_addr && rden_v[i]) begin
                chk("ram_addr", 32'(addr_v[i]), 32'(a));
                a = a + 8'd1;
            end
            if (valid_v[i] && rdy_v[i]) begin
                wa = b + 8'(k);
                chk("m_data", data_v[i], 32'(wa) * 32'd3);
`ifdef DPRAM_RD_LAST_EN
                chk("m_last", 32'(last_v[i]), 32'(k == l - 1));
`endif
                k++;
            end
            tick();
            e++;
        end
        chk("beats", 32'(k), 32'(l));
        if (first_exp >= 0) chk("first_valid_edge", 32'(first), 32'(first_exp));
        chk("done_pulse", 32'(done_v[i]), 32'd1);
        chk("busy_clear", 32'(busy_v[i]), 32'd0);
        chk("reads_issued", 32'(rd_cnt[i] - cnt0), 32'(l));
        tick();
        chk("done_low", 32'(done_v[i]), 32'd0);
        chk("valid_idle", 32'(valid_v[i]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'(k) * 32'd3;
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
        rst_n   = 1'b0;
        start_v = '0;
        base_v  = '0;
        len_v   = '0;
        rdy_v   = 2'b11;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
            chk("rst_done", 32'(done_v[i]), 32'd0);
            chk("rst_rden", 32'(rden_v[i]), 32'd0);
            chk("rst_addr", 32'(addr_v[i]), 32'd0);
            chk("rst_valid", 32'(valid_v[i]), 32'd0);
            chk("rst_data", data_v[i], 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // PIPELINE=1 block: 0x30..0x45, first valid at edge 3.
        pulse_start(0, 8'h10, 9'd8, c0);
        chk("busy_set", 32'(busy_v[0]), 32'd1);
        collect(0, 8'h10, 8, c0, 3, 1'b1, 1'b1);

        // PIPELINE=2 with address wrap FE,FF,00,01; first valid at edge 4.
        pulse_start(1, 8'hFE, 9'd4, c0);
        collect(1, 8'hFE, 4, c0, 4, 1'b1, 1'b1);

        // Zero-length start: done only, no RAM access, busy never set.
        pulse_start(0, 8'h55, 9'd0, c0);
        chk("len0_done", 32'(done_v[0]), 32'd1);
        chk("len0_busy", 32'(busy_v[0]), 32'd0);
        chk("len0_rden", 32'(rden_v[0]), 32'd0);
        tick();
        chk("len0_done_low", 32'(done_v[0]), 32'd0);
        chk("len0_no_reads", 32'(rd_cnt[0] - c0), 32'd0);

        // Backpressure: 20 stalled cycles allow exactly 4 reads, head frozen on word 0.
        rdy_v[0] = 1'b0;
        pulse_start(0, 8'h30, 9'd8, c0);
        repeat (10) tick();
        chk("stall_valid", 32'(valid_v[0]), 32'd1);
        chk("stall_data_a", data_v[0], 32'h90);
        repeat (10) tick();
        chk("stall_data_b", data_v[0], 32'h90);
        chk("stall_reads", 32'(rd_cnt[0] - c0), 32'd4);
        rdy_v[0] = 1'b1;
        collect(0, 8'h30, 8, c0, -1, 1'b0, 1'b0);

        // Second start while busy must be ignored.
        pulse_start(0, 8'h20, 9'd6, c0);
        tick();
        start_v[0] = 1'b1;
        base_v[0]  = 8'h80;
        len_v[0]   = 9'd3;
        tick();
        start_v[0] = 1'b0;
        chk("busy_hold", 32'(busy_v[0]), 32'd1);
        collect(0, 8'h20, 6, c0, -1, 1'b0, 1'b0);

        // Asynchronous reset after three accepted words.
        pulse_start(0, 8'h40, 9'd8, c0);
        n = 0;
        guard = 0;
        while (n < 3 && guard < 50) begin
            if (valid_v[0] && rdy_v[0]) begin
                chk("pre_rst_data", data_v[0], (32'h40 + 32'(n)) * 32'd3);
                n++;
            end
            tick();
            guard++;
        end
        chk("pre_rst_beats", 32'(n), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_rst_done", 32'(done_v[0]), 32'd0);
        chk("mid_rst_rden", 32'(rden_v[0]), 32'd0);
        chk("mid_rst_addr", 32'(addr_v[0]), 32'd0);
        chk("mid_rst_valid", 32'(valid_v[0]), 32'd0);
        chk("mid_rst_data", data_v[0], 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(done_v[0]), 32'd0);
        chk("post_rst_valid", 32'(valid_v[0]), 32'd0);
        pulse_start(0, 8'h05, 9'd5, c0);
        collect(0, 8'h05, 5, c0, 3, 1'b1, 1'b1);

        // Maximum length: full 2^AW words wrapping once, PIPELINE=2.
        pulse_start(1, 8'h80, 9'd256, c0);
        collect(1, 8'h80, 256, c0, 4, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
